// File: rtl/fp_seq_alu.sv
// fp_seq_alu: multi-cycle floating-point unit (add, sub, mul, div) on one shared datapath.
// Result appears exactly MAN_W+4 cycles after the accept edge for every operation.
// Optional feature macro FP_ROUND_NEAREST_EN: round-to-nearest-even using guard/round/sticky;
// when undefined the result is truncated (round toward zero) with identical latency.
module fp_seq_alu #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                 clk,
   input  logic                 areset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic [1:0]           selectFPOperation,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] fpResult,
   output logic [3:0]           fpFlags
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int F    = MAN_W + 1;            // significand including hidden bit
   localparam int WN   = 2 * F;                // working window, binary point at bit WN-2
   localparam int LW   = $clog2(WN);
   localparam int EW   = EXP_W + 2;            // signed internal exponent
   localparam int CW   = $clog2(MAN_W + 3);    // EXEC cycle counter
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
   localparam logic [1:0] OP_MUL = 2'b10, OP_DIV = 2'b11, OP_SUB = 2'b01;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_NORM, S_DONE} state_t;
   state_t r_state, w_state_next;

   logic [W-1:0]          r_a, r_b, r_result;
   logic [1:0]            r_op;
   logic [CW-1:0]         r_cnt;
   logic [WN-1:0]         r_man;               // value = r_man / 2^(WN-2) * 2^(r_exp-BIAS)
   logic [F+1:0]          r_rem;               // divider partial remainder
   logic signed [EW-1:0]  r_exp;
   logic                  r_sign;
   logic [3:0]            r_flags;

   // operand decode, denormals flushed to signed zero
   logic [W-1:0]          w_opnd [2];
   logic                  w_s [2], w_zero [2], w_inf [2], w_nan [2];
   logic [EXP_W-1:0]      w_e [2];
   logic [F-1:0]          w_m [2];
   logic signed [EW-1:0]  w_xe [2];
   assign w_opnd[0] = r_a;
   assign w_opnd[1] = r_b;
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dec
         assign w_s[gi]    = w_opnd[gi][W-1];
         assign w_e[gi]    = w_opnd[gi][W-2 -: EXP_W];
         assign w_zero[gi] = (w_e[gi] == '0);
         assign w_inf[gi]  = (w_e[gi] == '1) && (w_opnd[gi][MAN_W-1:0] == '0);
         assign w_nan[gi]  = (w_e[gi] == '1) && (w_opnd[gi][MAN_W-1:0] != '0);
         assign w_m[gi]    = w_zero[gi] ? '0 : {1'b1, w_opnd[gi][MAN_W-1:0]};
         assign w_xe[gi]   = $signed({2'b00, w_e[gi]});
      end
   endgenerate

   // add/sub: align the smaller magnitude, fold shifted-out bits into its LSB as sticky
   logic                  w_sb_eff, w_eff_sub, w_a_big, w_lost;
   logic [EXP_W-1:0]      w_ex, w_d;
   logic [WN-1:0]         w_xl, w_yl, w_ys, w_sum;
   assign w_sb_eff  = w_s[1] ^ (r_op == OP_SUB);
   assign w_eff_sub = w_s[0] ^ w_sb_eff;
   assign w_a_big   = {w_e[0], w_m[0]} >= {w_e[1], w_m[1]};
   assign w_ex      = w_a_big ? w_e[0] : w_e[1];
   assign w_d       = w_a_big ? (w_e[0] - w_e[1]) : (w_e[1] - w_e[0]);
   assign w_xl      = WN'(w_a_big ? w_m[0] : w_m[1]) << MAN_W;
   assign w_yl      = WN'(w_a_big ? w_m[1] : w_m[0]) << MAN_W;
   assign w_ys      = w_yl >> w_d;
   assign w_lost    = (w_ys << w_d) != w_yl;
   assign w_sum     = w_eff_sub ? (w_xl - (w_ys | WN'(w_lost))) : (w_xl + (w_ys | WN'(w_lost)));

   // mul: one shift-add partial product per EXEC cycle for the first F cycles
   logic [WN-1:0]         w_pp;
   assign w_pp = ((r_cnt < CW'(F)) && w_m[1][r_cnt]) ? (WN'(w_m[0]) << r_cnt) : '0;

   // div: restoring, dividend pre-doubled when A < B so every quotient starts with 1
   logic                  w_a_lt_b, w_qbit;
   logic [F+1:0]          w_rem_in, w_rem_sub, w_rem_next;
   assign w_a_lt_b   = w_m[0] < w_m[1];
   assign w_rem_in   = (r_cnt == '0) ? (w_a_lt_b ? {1'b0, w_m[0], 1'b0} : {2'b00, w_m[0]}) : r_rem;
   assign w_qbit     = w_rem_in >= {2'b00, w_m[1]};
   assign w_rem_sub  = w_qbit ? (w_rem_in - {2'b00, w_m[1]}) : w_rem_in;
   assign w_rem_next = w_rem_sub << 1;

   // normalisation: move the leading one to the top of the window
   logic [LW-1:0]         w_lead;
   logic [WN-1:0]         w_shift;
   logic signed [EW-1:0]  w_nexp, w_fexp;
   // leading-one search and exponent adjust
   always_comb begin
      w_lead = '0;
      for (int i = 0; i < WN; i++) begin
         if (r_man[i]) w_lead = LW'(i);
      end
      w_shift = r_man << (LW'(WN - 1) - w_lead);
      w_nexp  = r_exp + EW'(w_lead) - EW'(WN - 2);
   end

   logic [F-1:0]          w_mant;
   logic [F:0]            w_mant_rnd;
   logic [MAN_W-1:0]      w_frac;
   logic                  w_inc;
   assign w_mant = w_shift[WN-1 -: F];
`ifdef FP_ROUND_NEAREST_EN
   logic w_g, w_r, w_st;
   assign w_g   = w_shift[WN-1-F];
   assign w_r   = w_shift[WN-2-F];
   assign w_st  = (|w_shift[WN-3-F:0]) | (r_rem != '0);
   assign w_inc = w_g & (w_r | w_st | w_mant[0]);
`else
   assign w_inc = 1'b0;
`endif
   assign w_mant_rnd = {1'b0, w_mant} + (F+1)'(w_inc);
   assign w_fexp     = w_nexp + EW'(w_mant_rnd[F]);
   assign w_frac     = w_mant_rnd[F] ? '0 : w_mant_rnd[MAN_W-1:0];

   // special-operand classification
   logic w_invalid, w_dbz, w_res_inf, w_inf_sign, w_zero_sp;
   always_comb begin
      w_invalid  = w_nan[0] | w_nan[1];
      w_dbz      = 1'b0;
      w_res_inf  = 1'b0;
      w_zero_sp  = 1'b0;
      w_inf_sign = w_s[0] ^ w_s[1];
      case (r_op)
         OP_MUL: begin
            w_invalid = w_invalid | (w_inf[0] & w_zero[1]) | (w_zero[0] & w_inf[1]);
            w_res_inf = w_inf[0] | w_inf[1];
         end
         OP_DIV: begin
            w_invalid = w_invalid | (w_zero[0] & w_zero[1]) | (w_inf[0] & w_inf[1]);
            w_dbz     = w_zero[1] & ~w_inf[0];
            w_res_inf = w_inf[0];
            w_zero_sp = w_inf[1];
         end
         default: begin
            w_invalid  = w_invalid | (w_inf[0] & w_inf[1] & w_eff_sub);
            w_res_inf  = w_inf[0] | w_inf[1];
            w_inf_sign = w_inf[0] ? w_s[0] : w_sb_eff;
         end
      endcase
   end

   // final result selection: specials, exact zero, overflow, underflow, normal
   logic [W-1:0] w_res;
   logic [3:0]   w_flg;
   always_comb begin
      w_res = '0;
      w_flg = '0;
      if (w_invalid) begin
         w_res = QNAN;
         w_flg = 4'b1000;
      end else if (w_dbz || w_res_inf) begin
         w_res = {w_inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_flg = {1'b0, w_dbz, 2'b00};
      end else if (w_zero_sp || (r_man == '0)) begin
         w_res = {r_op[1] & r_sign, {(W-1){1'b0}}};
      end else if (w_fexp >= EXP_MAX) begin
         w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_flg = 4'b0010;
      end else if (w_fexp < EXP_ONE) begin
         w_res = {r_sign, {(W-1){1'b0}}};
         w_flg = 4'b0001;
      end else begin
         w_res = {r_sign, w_fexp[EXP_W-1:0], w_frac};
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (areset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // FSM next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (in_valid) w_state_next = S_EXEC;
         S_EXEC: if (r_cnt == CW'(MAN_W + 2)) w_state_next = S_NORM;
         S_NORM: w_state_next = S_DONE;
         S_DONE: if (out_ready) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready  = (r_state == S_IDLE) && !areset;
      out_valid = (r_state == S_DONE);
      fpResult  = r_result;
      fpFlags   = r_flags;
   end

   // datapath: capture on accept, iterate in EXEC, round/pack in NORM
   always_ff @(posedge clk) begin
      if (areset) begin
         r_a <= '0; r_b <= '0; r_op <= '0; r_cnt <= '0;
         r_man <= '0; r_rem <= '0; r_exp <= '0; r_sign <= 1'b0;
         r_result <= '0; r_flags <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_a <= a; r_b <= b; r_op <= selectFPOperation;
               r_cnt <= '0; r_man <= '0; r_rem <= '0; r_flags <= '0;
            end
            S_EXEC: begin
               r_cnt <= r_cnt + 1'b1;
               case (r_op)
                  OP_MUL: begin
                     r_man <= r_man + w_pp;
                     if (r_cnt == '0) begin
                        r_exp  <= w_xe[0] + w_xe[1] - EW'(BIAS);
                        r_sign <= w_s[0] ^ w_s[1];
                     end
                  end
                  OP_DIV: begin
                     r_man <= {r_man[WN-2:0], w_qbit};
                     r_rem <= w_rem_next;
                     if (r_cnt == '0) begin
                        r_exp  <= w_xe[0] - w_xe[1] + EW'(BIAS + MAN_W - 2) - EW'(w_a_lt_b);
                        r_sign <= w_s[0] ^ w_s[1];
                     end
                  end
                  default: if (r_cnt == '0) begin
                     r_man  <= w_sum;
                     r_exp  <= $signed({2'b00, w_ex});
                     r_sign <= w_a_big ? w_s[0] : w_sb_eff;
                  end
               endcase
            end
            S_NORM: begin
               r_result <= w_res;
               r_flags  <= w_flg;
            end
            default: ;
         endcase
      end
   end
endmodule
